axis_iq_pkt_power: RTL and testbench
====================================

Name: axis_iq_pkt_power

Overview:
- Sits directly downstream of the gain block's output payload stream.
- Forwards the sc16 stream unchanged, with one register stage.
- Accumulates per-packet signal energy: sum of I^2+Q^2 over all beats of a packet.
- At each tlast, emits one report beat containing energy and beat count, on a side AXI-Stream port that software or a readback register consumes.

Parameters:
- ACC_W, 48, energy accumulator/report width in bits; minimum 33.
- CNT_W, 16, beat-count width in bits.
- DROP_REPORTS, 0, 0 = stall input on the last beat while a report is pending; 1 = discard the new report and bump the drop counter.

Ports:
- axis_data_clk  in  1  block clock.
- axis_data_rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  32  I in [31:16], Q in [15:0], both signed two's complement.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  forwarded sample.
- m_axis_tlast  out  1  forwarded tlast.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_pwr_tdata  out  ACC_W  packet energy, saturating.
- m_pwr_count  out  CNT_W  beats in packet, saturating.
- m_pwr_tvalid  out  1  report valid.
- m_pwr_tready  in  1  report ready.
- drop_count  out  16  reports discarded (DROP_REPORTS=1 only), wraps.

Behaviour:
- Reset: all valids 0, data/tlast registers 0, accumulator 0, count 0, drop_count 0. Reset asserted mid-packet discards the partial packet; the next accepted beat starts a fresh packet.
- Data path: one output register. out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = out_free && !stall.
- stall = s_axis_tlast && m_pwr_tvalid && !m_pwr_tready && (DROP_REPORTS==0).
- Beat accepted (tvalid && tready): register it to m_axis on the same edge. Latency 1 cycle; full throughput of 1 beat/cycle under continuous ready. tdata/tlast unchanged bit-for-bit.
- Energy per beat: e = I*I + Q*Q, computed as signed 17-bit products summed to 32 bits unsigned. Max 0x8000_0000 at I=Q=-32768; no overflow.
- acc_next = acc + e, saturating at 2^ACC_W-1.
- cnt_next = cnt + 1, saturating at 2^CNT_W-1.
- Non-last accepted beat: acc <= acc_next, cnt <= cnt_next.
- Last accepted beat:
  - m_pwr_tdata <= acc_next, m_pwr_count <= cnt_next, m_pwr_tvalid <= 1.
  - acc <= 0, cnt <= 0.
  - Report valid is visible the cycle after the last beat is accepted, the same cycle that beat appears on m_axis.
- Report handshake: m_pwr_tvalid clears on m_pwr_tvalid && m_pwr_tready, unless a new last beat is accepted in the same cycle, in which case the new report loads and valid stays 1.
- Report port full (valid && !ready) when a last beat arrives:
  - DROP_REPORTS=0: the last beat is held (tready=0) until the report drains; non-last beats are never stalled by the report port.
  - DROP_REPORTS=1: the beat is accepted and the data path is unaffected. The pending report is kept, the new report is discarded, drop_count increments (wraps at 0xFFFF), and acc/cnt still clear.
- A single-beat packet (tlast on the first beat) reports count 1.
- m_axis holds tdata/tlast/tvalid stable while tvalid && !tready.

Test Plan:
- Reset, then 4-beat packet of 0x0003_0004, all readies high → m_axis carries the identical 4 beats at 1-cycle latency; report tdata=100, count=4.
- Single beat 0x8000_8000 with tlast → report tdata=0x8000_0000, count=1; data forwarded unchanged.
- DROP_REPORTS=0, m_pwr_tready=0, two back-to-back 2-beat packets of 0x0001_0001 → second last beat stalls (s_axis_tready=0) until m_pwr_tready=1; reports 4/2 then 4/2, none lost.
- DROP_REPORTS=1, same stimulus → no input stall; first report (4/2) stays held; drop_count=1.
- Random m_axis_tready toggling over 1000 random beats → output stream equals input stream exactly; no beat duplicated or lost.
- ACC_W=33, packet of 4 beats of 0x8000_8000 → report saturates at 0x1_FFFF_FFFF; next packet 0x0000_0002 (1 beat) → report 4, confirming the clear.

Source files
------------

// File: rtl/axis_iq_pkt_power.sv
// -----------------------------------------------------------------------------
// axis_iq_pkt_power
//
// Sits on the gain block's output payload stream. Forwards the sc16 stream
// through one register stage and measures per-packet signal energy. The energy
// is the sum of I^2+Q^2 over the packet, and it is reported together with the
// beat count. One report beat is emitted on a side stream at every tlast.
//
// Ports
//   axis_data_clk, axis_data_rst_n   clock, asynchronous active-low reset
//   s_axis_*                         sc16 input (I = [31:16], Q = [15:0])
//   m_axis_*                         forwarded sc16 output, 1-cycle latency
//   m_pwr_tdata / m_pwr_count        packet energy / beat count, saturating
//   m_pwr_tvalid / m_pwr_tready      report handshake
//   drop_count                       reports discarded (DROP_REPORTS=1), wraps
//
// Handshake semantics (all three streams): a transfer happens on a rising edge
// where tvalid && tready are both high. A producer holds tdata/tlast/tvalid
// stable while tvalid && !tready. tvalid never depends on tready.
// -----------------------------------------------------------------------------
module axis_iq_pkt_power #(
    parameter int ACC_W        = 48,
    parameter int CNT_W        = 16,
    parameter int DROP_REPORTS = 0
) (
    input  logic             axis_data_clk,
    input  logic             axis_data_rst_n,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [ACC_W-1:0] m_pwr_tdata,
    output logic [CNT_W-1:0] m_pwr_count,
    output logic             m_pwr_tvalid,
    input  logic             m_pwr_tready,
    output logic [15:0]      drop_count
);

    logic             out_free;
    logic             stall;
    logic             accept;
    logic             report_busy;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic signed [15:0] samp_i;
    logic signed [15:0] samp_q;
    logic signed [31:0] i_sq;
    logic signed [31:0] q_sq;
    logic [31:0]        energy;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;

    // The output register can take a beat when it is empty or draining now.
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign report_busy = m_pwr_tvalid && !m_pwr_tready;

    // Only a last beat can be held back by the report port, and only when
    // reports must not be lost.
    assign stall         = s_axis_tlast && report_busy && (DROP_REPORTS == 0);
    assign s_axis_tready = out_free && !stall;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Each square is at most 2^30 (at -32768). The sum is at most 2^31, so
    // 32 unsigned bits hold it without overflow.
    assign samp_i = s_axis_tdata[31:16];
    assign samp_q = s_axis_tdata[15:0];
    assign i_sq   = 32'(samp_i) * 32'(samp_i);
    assign q_sq   = 32'(samp_q) * 32'(samp_q);
    assign energy = $unsigned(i_sq) + $unsigned(q_sq);

    // One extra bit catches the carry, and the carry saturates the result.
    assign acc_sum  = {1'b0, acc} + (ACC_W+1)'(energy);
    assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_pwr_tdata   <= '0;
            m_pwr_count   <= '0;
            m_pwr_tvalid  <= 1'b0;
            drop_count    <= '0;
            acc           <= '0;
            cnt           <= '0;
        end else begin
            // Data path register
            if (accept) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            // Energy accumulation and report generation
            if (accept && s_axis_tlast) begin
                acc <= '0;
                cnt <= '0;
                if (!report_busy) begin
                    // The slot is empty or drains this edge, so the new report
                    // replaces it and valid stays high.
                    m_pwr_tdata  <= acc_next;
                    m_pwr_count  <= cnt_next;
                    m_pwr_tvalid <= 1'b1;
                end else begin
                    // Reachable only with DROP_REPORTS=1. Keep the pending report.
                    drop_count <= drop_count + 16'd1;
                end
            end else begin
                if (accept) begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                end
                if (m_pwr_tvalid && m_pwr_tready) begin
                    m_pwr_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_iq_pkt_power.sv
// -----------------------------------------------------------------------------
// tb_axis_iq_pkt_power
//
// Directed bench for axis_iq_pkt_power. It uses three instances:
//   dut0  default parameters (DROP_REPORTS=0)
//   dut1  DROP_REPORTS=1
//   dut2  ACC_W=33
//
// The instances share the data and ready inputs. Only the selected instance
// sees s_axis_tvalid, and its outputs are muxed onto the obs_* signals.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// after that point, or on the falling edge by the stream monitors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_iq_pkt_power;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tvalid;
    logic        m_tready;
    logic        p_tready;
    logic [1:0]  sel;
    logic        rand_rdy;

    logic        rdy0, rdy1, rdy2;
    logic [31:0] md0, md1, md2;
    logic        ml0, ml1, ml2;
    logic        mv0, mv1, mv2;
    logic [47:0] pd0, pd1;
    logic [32:0] pd2;
    logic [15:0] pc0, pc1, pc2;
    logic        pv0, pv1, pv2;
    logic [15:0] dc0, dc1, dc2;

    logic        obs_rdy;
    logic [31:0] obs_mdata;
    logic        obs_mlast;
    logic        obs_mvalid;
    logic [47:0] obs_pdata;
    logic [15:0] obs_pcnt;
    logic        obs_pvalid;
    logic [15:0] obs_drop;

    int          tests_run    = 0;
    int          tests_failed = 0;
    longint      cyc          = 0;
    int          popped       = 0;
    int          rpt_n        = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_iq_pkt_power dut0 (
        .axis_data_clk(clk), .axis_data_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid && sel == 2'd0), .s_axis_tready(rdy0),
        .m_axis_tdata(md0), .m_axis_tlast(ml0), .m_axis_tvalid(mv0),
        .m_axis_tready(m_tready),
        .m_pwr_tdata(pd0), .m_pwr_count(pc0), .m_pwr_tvalid(pv0),
        .m_pwr_tready(p_tready), .drop_count(dc0)
    );

    axis_iq_pkt_power #(.DROP_REPORTS(1)) dut1 (
        .axis_data_clk(clk), .axis_data_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid && sel == 2'd1), .s_axis_tready(rdy1),
        .m_axis_tdata(md1), .m_axis_tlast(ml1), .m_axis_tvalid(mv1),
        .m_axis_tready(m_tready),
        .m_pwr_tdata(pd1), .m_pwr_count(pc1), .m_pwr_tvalid(pv1),
        .m_pwr_tready(p_tready), .drop_count(dc1)
    );

    axis_iq_pkt_power #(.ACC_W(33)) dut2 (
        .axis_data_clk(clk), .axis_data_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid && sel == 2'd2), .s_axis_tready(rdy2),
        .m_axis_tdata(md2), .m_axis_tlast(ml2), .m_axis_tvalid(mv2),
        .m_axis_tready(m_tready),
        .m_pwr_tdata(pd2), .m_pwr_count(pc2), .m_pwr_tvalid(pv2),
        .m_pwr_tready(p_tready), .drop_count(dc2)
    );

    always_comb begin
        obs_rdy    = rdy0;
        obs_mdata  = md0;
        obs_mlast  = ml0;
        obs_mvalid = mv0;
        obs_pdata  = pd0;
        obs_pcnt   = pc0;
        obs_pvalid = pv0;
        obs_drop   = dc0;
        if (sel == 2'd1) begin
            obs_rdy    = rdy1;
            obs_mdata  = md1;
            obs_mlast  = ml1;
            obs_mvalid = mv1;
            obs_pdata  = pd1;
            obs_pcnt   = pc1;
            obs_pvalid = pv1;
            obs_drop   = dc1;
        end else if (sel == 2'd2) begin
            obs_rdy    = rdy2;
            obs_mdata  = md2;
            obs_mlast  = ml2;
            obs_mvalid = mv2;
            obs_pdata  = {15'd0, pd2};
            obs_pcnt   = pc2;
            obs_pvalid = pv2;
            obs_drop   = dc2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output stream scoreboard: each transfer must match the next accepted beat.
    always @(negedge clk) begin
        if (rst_n && obs_mvalid && m_tready) begin
            chk("m_axis_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("m_axis_beat", {obs_mlast, obs_mdata}, exp_q.pop_front());
                popped++;
            end
        end
        if (rst_n && obs_pvalid && p_tready) rpt_n++;
    end

    // Random backpressure on m_axis when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // --- driver tasks: entered and left 1 time unit after a rising edge ---
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (!obs_rdy && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("send_ready", obs_rdy, 1);
        @(posedge clk);
        exp_q.push_back({l, d});
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        longint c0;
        int     r0;
        int     p0;
        int     n;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        p_tready = 1'b1;
        sel      = 2'd0;
        rand_rdy = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(1);

        // Reset state
        chk("rst_mvalid", obs_mvalid, 0);
        chk("rst_mdata", obs_mdata, 0);
        chk("rst_mlast", obs_mlast, 0);
        chk("rst_pvalid", obs_pvalid, 0);
        chk("rst_pdata", obs_pdata, 0);
        chk("rst_pcnt", obs_pcnt, 0);
        chk("rst_drop", obs_drop, 0);
        chk("rst_sready", obs_rdy, 1);

        // 4-beat packet of (3,4): energy 25 per beat, one beat per cycle
        c0 = cyc;
        r0 = rpt_n;
        send(32'h0003_0004, 1'b0);
        chk("t1_latency_valid", obs_mvalid, 1);
        chk("t1_latency_data", obs_mdata, 32'h0003_0004);
        chk("t1_no_early_report", obs_pvalid, 0);
        send(32'h0003_0004, 1'b0);
        send(32'h0003_0004, 1'b0);
        send(32'h0003_0004, 1'b1);
        idle();
        chk("t1_throughput", cyc - c0, 4);
        chk("t1_last_fwd", obs_mlast, 1);
        chk("t1_pvalid", obs_pvalid, 1);
        chk("t1_energy", obs_pdata, 100);
        chk("t1_count", obs_pcnt, 4);
        step(1);
        chk("t1_report_drained", obs_pvalid, 0);
        chk("t1_report_xfers", rpt_n - r0, 1);

        // Single-beat packet at full negative scale
        send(32'h8000_8000, 1'b1);
        idle();
        chk("t2_energy", obs_pdata, 48'h0000_8000_0000);
        chk("t2_count", obs_pcnt, 1);
        chk("t2_data", obs_mdata, 32'h8000_8000);
        chk("t2_last", obs_mlast, 1);
        step(1);

        // DROP_REPORTS=0: the second last beat waits for the report port
        p_tready = 1'b0;
        send(32'h0001_0001, 1'b0);
        send(32'h0001_0001, 1'b1);
        idle();
        chk("t3_rpt_a_valid", obs_pvalid, 1);
        chk("t3_rpt_a_energy", obs_pdata, 4);
        chk("t3_rpt_a_count", obs_pcnt, 2);
        send(32'h0002_0002, 1'b0);
        chk("t3_nonlast_not_stalled", obs_mdata, 32'h0002_0002);
        s_tdata  = 32'h0002_0002;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        #1;
        chk("t3_stall_0", obs_rdy, 0);
        step(3);
        chk("t3_stall_3", obs_rdy, 0);
        chk("t3_rpt_a_held", obs_pdata, 4);
        chk("t3_rpt_a_held_valid", obs_pvalid, 1);
        r0 = rpt_n;
        p_tready = 1'b1;
        send(32'h0002_0002, 1'b1);
        idle();
        chk("t3_rpt_b_valid", obs_pvalid, 1);
        chk("t3_rpt_b_energy", obs_pdata, 16);
        chk("t3_rpt_b_count", obs_pcnt, 2);
        chk("t3_rpt_a_taken", rpt_n - r0, 1);
        step(1);
        chk("t3_rpt_b_taken", rpt_n - r0, 2);
        chk("t3_drained", obs_pvalid, 0);
        chk("t3_no_drop", obs_drop, 0);

        // DROP_REPORTS=1: no stall, the pending report is kept, the new one is dropped
        sel = 2'd1;
        p_tready = 1'b0;
        send(32'h0001_0001, 1'b0);
        send(32'h0001_0001, 1'b1);
        idle();
        chk("t4_rpt_a_energy", obs_pdata, 4);
        chk("t4_rpt_a_count", obs_pcnt, 2);
        send(32'h0002_0002, 1'b0);
        c0 = cyc;
        send(32'h0002_0002, 1'b1);
        idle();
        chk("t4_no_stall", cyc - c0, 1);
        chk("t4_data_fwd", {obs_mlast, obs_mdata}, {1'b1, 32'h0002_0002});
        chk("t4_kept_valid", obs_pvalid, 1);
        chk("t4_kept_energy", obs_pdata, 4);
        chk("t4_kept_count", obs_pcnt, 2);
        chk("t4_drop_count", obs_drop, 1);
        p_tready = 1'b1;
        step(1);
        chk("t4_drained", obs_pvalid, 0);
        send(32'h0000_0002, 1'b1);
        idle();
        chk("t4_clear_energy", obs_pdata, 4);
        chk("t4_clear_count", obs_pcnt, 1);
        chk("t4_drop_stable", obs_drop, 1);
        step(1);

        // Random backpressure on m_axis over 1000 random beats
        sel = 2'd0;
        step(2);
        chk("t5_queue_empty_before", exp_q.size(), 0);
        p0 = popped;
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom, (i == 999) ? 1'b1 : 1'($urandom_range(0, 7) == 0));
        end
        idle();
        rand_rdy = 1'b0;
        step(1);
        m_tready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        chk("t5_all_delivered", exp_q.size(), 0);
        chk("t5_beat_count", popped - p0, 1000);
        step(1);

        // ACC_W=33 saturation, then clear
        sel = 2'd2;
        send(32'h8000_8000, 1'b0);
        send(32'h8000_8000, 1'b0);
        send(32'h8000_8000, 1'b0);
        send(32'h8000_8000, 1'b1);
        idle();
        chk("t6_sat_energy", obs_pdata, 48'h0001_FFFF_FFFF);
        chk("t6_sat_count", obs_pcnt, 4);
        step(1);
        send(32'h0000_0002, 1'b1);
        idle();
        chk("t6_clear_energy", obs_pdata, 4);
        chk("t6_clear_count", obs_pcnt, 1);
        step(1);

        // Reset mid-packet discards the partial packet
        sel = 2'd0;
        send(32'h7FFF_7FFF, 1'b0);
        send(32'h7FFF_7FFF, 1'b0);
        idle();
        step(3);
        chk("t7_drained_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("t7_async_mvalid", obs_mvalid, 0);
        chk("t7_async_mdata", obs_mdata, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        send(32'h0001_0000, 1'b1);
        idle();
        chk("t7_fresh_energy", obs_pdata, 1);
        chk("t7_fresh_count", obs_pcnt, 1);
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
